// File: rtl/dcache_sa_pkg.sv
// dcache_pkg: shared definitions for the set-associative data cache.
//   state_t  - controller states
//   clog2    - ceiling log2 used to derive field widths
//   OFF_W / IDX_W / TAG_W - address field widths for the default
//   configuration (32-bit address, 64-bit word, 16 sets)
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    RESP,
    FL_SCAN,
    FL_WB,
    FL_DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_SETS   = 16;

  localparam int OFF_W = clog2(DEF_DATA_W / 8);
  localparam int IDX_W = clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

endpackage

// File: rtl/dcache_sa_if.sv
// dcache_sa_if: CPU-side and memory-side bus of the data cache.
//   slave  - the cache's view (CPU requests and memory responses in,
//            CPU responses and memory requests out)
//   master - the environment's view (CPU/pipeline plus memory model)
interface dcache_sa_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic                  cpu_rd;
  logic [DATA_W/8-1:0]   cpu_wr;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_busy;
  logic                  flush_req;
  logic                  flush_done;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_rd_addr;
  logic [DATA_W-1:0]     mem_rd_data;
  logic                  mem_rd_valid;
  logic                  mem_wr_en;
  logic [ADDR_W-1:0]     mem_wr_addr;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_wr_ack;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, flush_req,
           mem_rd_data, mem_rd_valid, mem_wr_ack,
    output cpu_rdata, cpu_ready, cpu_busy, flush_done,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, flush_req,
           mem_rd_data, mem_rd_valid, mem_wr_ack,
    input  cpu_rdata, cpu_ready, cpu_busy, flush_done,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

endinterface

// File: rtl/dcache_sa_way.sv
// dcache_way: storage for one way of the cache.
//   clk, rst  - clock, synchronous active-low reset (clears valid/dirty)
//   idx       - set index shared by the read and write ports
//   rd_*      - combinational read of valid, dirty, tag and data
//   data_we   - byte-strobed data write (wr_strb, wr_data)
//   tag_we    - installs wr_tag and marks the line valid
//   dirty_we  - writes wr_dirty
module dcache_way
  import dcache_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SETS   = 16,
  parameter int TAG_W  = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [clog2(SETS)-1:0]    idx,
  output logic                      rd_valid,
  output logic                      rd_dirty,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [DATA_W-1:0]         rd_data,
  input  logic                      data_we,
  input  logic [DATA_W/8-1:0]       wr_strb,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      tag_we,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic                      dirty_we,
  input  logic                      wr_dirty
);

  logic [TAG_W-1:0]  tags [SETS];
  logic [DATA_W-1:0] data [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx];

  // Only the status bits need a reset; tag and data are qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (tag_we) begin
        tags[idx]  <= wr_tag;
        valid[idx] <= 1'b1;
      end
      if (dirty_we) dirty[idx] <= wr_dirty;
      if (data_we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (wr_strb[b]) data[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_sa.sv
// dcache_sa: set-associative, write-back, write-allocate data cache with
// round-robin replacement and a whole-cache flush.
//   clk, rst - clock, synchronous active-low reset
//   bus      - CPU request/response, flush handshake and memory
//              read/write request/acknowledge channels (slave modport)
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  dcache_sa_if.slave bus
);

  localparam int OFF_BITS = clog2(DATA_W / 8);
  localparam int IDX_BITS = clog2(SETS);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? clog2(WAYS) : 1;
  localparam int STRB_W   = DATA_W / 8;
  localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);
  localparam logic [IDX_BITS-1:0] LAST_SET = IDX_BITS'(SETS - 1);
  localparam logic [ADDR_W-1:0]   OFF_MASK = ADDR_W'((1 << OFF_BITS) - 1);

  state_t              state;
  logic [WAY_BITS-1:0] vic_way;
  logic [WAY_BITS-1:0] scan_way;
  logic [IDX_BITS-1:0] scan_set;
  logic [WAY_BITS-1:0] rr [SETS];
  logic [DATA_W-1:0]   resp_data;
  logic                mem_rd_en_q, mem_wr_en_q, flush_done_q;
  logic [ADDR_W-1:0]   mem_rd_addr_q, mem_wr_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;

  logic                is_wr, is_req, in_flush, scan_last;
  logic [IDX_BITS-1:0] cpu_idx, way_idx;
  logic [TAG_BITS-1:0] cpu_tag;

  logic                w_valid [WAYS];
  logic                w_dirty [WAYS];
  logic [TAG_BITS-1:0] w_tag   [WAYS];
  logic [DATA_W-1:0]   w_data  [WAYS];
  logic [WAYS-1:0]     data_we, tag_we, dirty_we;
  logic [STRB_W-1:0]   wr_strb;
  logic [DATA_W-1:0]   wr_data, fill_data;
  logic                wr_dirty;

  logic                hit, cpu_ready;
  logic [WAY_BITS-1:0] hit_way, victim;
  logic [DATA_W-1:0]   hit_data;

  assign is_wr     = |bus.cpu_wr;
  assign is_req    = is_wr | bus.cpu_rd;
  assign cpu_idx   = bus.cpu_addr[OFF_BITS +: IDX_BITS];
  assign cpu_tag   = bus.cpu_addr[ADDR_W-1 -: TAG_BITS];
  assign in_flush  = (state == FL_SCAN) || (state == FL_WB) || (state == FL_DONE);
  assign way_idx   = in_flush ? scan_set : cpu_idx;
  assign scan_last = (scan_set == LAST_SET) && (scan_way == LAST_WAY);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way #(.DATA_W(DATA_W), .SETS(SETS), .TAG_W(TAG_BITS)) u_way (
      .clk      (clk),
      .rst      (rst),
      .idx      (way_idx),
      .rd_valid (w_valid[g]),
      .rd_dirty (w_dirty[g]),
      .rd_tag   (w_tag[g]),
      .rd_data  (w_data[g]),
      .data_we  (data_we[g]),
      .wr_strb  (wr_strb),
      .wr_data  (wr_data),
      .tag_we   (tag_we[g]),
      .wr_tag   (cpu_tag),
      .dirty_we (dirty_we[g]),
      .wr_dirty (wr_dirty)
    );
  end

  // Tag match, and victim choice: the lowest invalid way wins, otherwise
  // the set's round-robin pointer. The descending loop leaves the lowest.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    victim   = rr[cpu_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (w_valid[w] && (w_tag[w] == cpu_tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_BITS'(w);
        hit_data = w_data[w];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) victim = WAY_BITS'(w);
    end
  end

  // Fill word with the pending store's strobed bytes merged over it.
  always_comb begin
    fill_data = bus.mem_rd_data;
    for (int b = 0; b < STRB_W; b++) begin
      if (bus.cpu_wr[b]) fill_data[8*b +: 8] = bus.cpu_wdata[8*b +: 8];
    end
  end

  // Storage write controls for store hits, fills and dirty clears.
  always_comb begin
    data_we  = '0;
    tag_we   = '0;
    dirty_we = '0;
    wr_strb  = '0;
    wr_data  = bus.cpu_wdata;
    wr_dirty = 1'b0;
    case (state)
      IDLE: if (is_wr && hit) begin
        data_we[hit_way]  = 1'b1;
        dirty_we[hit_way] = 1'b1;
        wr_strb           = bus.cpu_wr;
        wr_dirty          = 1'b1;
      end
      WB:    if (bus.mem_wr_ack) dirty_we[vic_way] = 1'b1;
      FILL:  if (bus.mem_rd_valid) begin
        data_we[vic_way]  = 1'b1;
        tag_we[vic_way]   = 1'b1;
        dirty_we[vic_way] = 1'b1;
        wr_strb           = '1;
        wr_data           = fill_data;
        wr_dirty          = is_wr;
      end
      FL_WB: if (bus.mem_wr_ack) dirty_we[scan_way] = 1'b1;
      default: ;
    endcase
  end

  // Controller: miss handling, flush scan and registered memory requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      vic_way       <= '0;
      scan_way      <= '0;
      scan_set      <= '0;
      resp_data     <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      flush_done_q  <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_req && !hit) begin
            vic_way <= victim;
            if (w_valid[victim] && w_dirty[victim]) begin
              state         <= WB;
              mem_wr_en_q   <= 1'b1;
              mem_wr_addr_q <= {w_tag[victim], cpu_idx, {OFF_BITS{1'b0}}};
              mem_wr_data_q <= w_data[victim];
            end else begin
              state         <= FILL;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= bus.cpu_addr & ~OFF_MASK;
            end
          end else if (!is_req && bus.flush_req) begin
            state    <= FL_SCAN;
            scan_set <= '0;
            scan_way <= '0;
          end
        end
        WB: if (bus.mem_wr_ack) begin
          state         <= FILL;
          mem_wr_en_q   <= 1'b0;
          mem_rd_en_q   <= 1'b1;
          mem_rd_addr_q <= bus.cpu_addr & ~OFF_MASK;
        end
        FILL: if (bus.mem_rd_valid) begin
          state       <= RESP;
          mem_rd_en_q <= 1'b0;
          resp_data   <= is_wr ? fill_data : bus.mem_rd_data;
          rr[cpu_idx] <= (rr[cpu_idx] == LAST_WAY) ? '0 : rr[cpu_idx] + 1'b1;
        end
        RESP: state <= IDLE;
        FL_SCAN: begin
          if (w_valid[scan_way] && w_dirty[scan_way]) begin
            state         <= FL_WB;
            mem_wr_en_q   <= 1'b1;
            mem_wr_addr_q <= {w_tag[scan_way], scan_set, {OFF_BITS{1'b0}}};
            mem_wr_data_q <= w_data[scan_way];
          end else if (scan_last) begin
            state        <= FL_DONE;
            flush_done_q <= 1'b1;
          end else if (scan_way == LAST_WAY) begin
            scan_way <= '0;
            scan_set <= scan_set + 1'b1;
          end else begin
            scan_way <= scan_way + 1'b1;
          end
        end
        // Back to the same slot: its dirty bit is now clear, so the scan moves on.
        FL_WB: if (bus.mem_wr_ack) begin
          state       <= FL_SCAN;
          mem_wr_en_q <= 1'b0;
        end
        FL_DONE: begin
          state        <= IDLE;
          flush_done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign cpu_ready       = rst && (((state == IDLE) && is_req && hit) || (state == RESP));
  assign bus.cpu_ready   = cpu_ready;
  assign bus.cpu_busy    = rst && is_req && !cpu_ready;
  assign bus.cpu_rdata   = !rst ? '0 :
                           ((state == IDLE) && is_req && hit) ? hit_data : resp_data;
  assign bus.flush_done  = flush_done_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;

endmodule
